// File: rtl/priority_arbiter_pkg.sv
// Shared definitions for the priority arbiter: index-width helper and mode constants.
package prio_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between the requesters/consumer (master) and the arbiter (slave).
interface priority_arbiter_if
    import prio_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_w(N)
) ();

    logic [N-1:0]     req;
    logic             ack;
    logic [N-1:0]     grant;
    logic [IDX_W-1:0] grant_idx;
    logic             valid;

    modport master (output req, ack, input grant, grant_idx, valid);
    modport slave  (input req, ack, output grant, grant_idx, valid);

endinterface

// File: rtl/priority_arbiter_encoder.sv
// Combinational highest-set-bit encoder with an any-bit-set flag.
module priority_encoder_n
    import prio_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     in_vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (in_vec[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Registered N-input arbiter, fixed (MSB wins) or round-robin, holding each grant until ack.
module priority_arbiter
    import prio_pkg::*;
#(
    parameter int N           = 8,
    parameter int ROUND_ROBIN = 1,
    parameter int IDX_W       = idx_w(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_arbiter_if.slave     bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state;
    logic [N-1:0]     mask;
    logic [N-1:0]     grant_q;
    logic [IDX_W-1:0] idx_q;

    logic [IDX_W-1:0] idx_masked;
    logic [IDX_W-1:0] idx_raw;
    logic             any_masked;
    logic             any_raw;
    logic [IDX_W-1:0] winner;
    logic             load;

    priority_encoder_n #(.N(N), .IDX_W(IDX_W)) u_enc_masked (
        .in_vec (bus.req & mask),
        .idx    (idx_masked),
        .any    (any_masked)
    );

    priority_encoder_n #(.N(N), .IDX_W(IDX_W)) u_enc_raw (
        .in_vec (bus.req),
        .idx    (idx_raw),
        .any    (any_raw)
    );

    // An empty masked search falls back to the full request vector, wrapping to the top.
    assign winner = ((ROUND_ROBIN == MODE_RR) && any_masked) ? idx_masked : idx_raw;
    assign load   = (state == IDLE) || bus.ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            mask    <= '1;
        end else if (load) begin
            if (any_raw) begin
                state   <= HOLD;
                grant_q <= N'(1) << winner;
                idx_q   <= winner;
                // Only indices below the winner stay eligible in the next masked search.
                if (ROUND_ROBIN == MODE_RR)
                    mask <= (N'(1) << winner) - N'(1);
            end else begin
                state   <= IDLE;
                grant_q <= '0;
                idx_q   <= '0;
            end
        end
    end

    assign bus.valid     = (state == HOLD);
    assign bus.grant     = grant_q;
    assign bus.grant_idx = idx_q;

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench: three arbiters (fixed N=4, round-robin N=4, fixed N=16) on one clock/reset.
module tb_priority_arbiter;

    typedef struct {
        int          sel;
        logic        v;
        logic [15:0] g;
        logic [7:0]  i;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];

    priority_arbiter_if #(.N(4))  if_f ();
    priority_arbiter_if #(.N(4))  if_r ();
    priority_arbiter_if #(.N(16)) if_w ();

    priority_arbiter #(.N(4),  .ROUND_ROBIN(0)) dut_f (.clk(clk), .rst(rst), .bus(if_f));
    priority_arbiter #(.N(4),  .ROUND_ROBIN(1)) dut_r (.clk(clk), .rst(rst), .bus(if_r));
    priority_arbiter #(.N(16), .ROUND_ROBIN(0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm,
                               input logic act_v, input logic [15:0] act_g, input logic [7:0] act_i,
                               input logic exp_v, input logic [15:0] exp_g, input logic [7:0] exp_i);
        checks++;
        if (act_v !== exp_v || act_g !== exp_g || act_i !== exp_i) begin
            failures++;
            $display("[TB] FAIL %s: got valid=%b grant=%h idx=%0d, expected valid=%b grant=%h idx=%0d",
                     nm, act_v, act_g, act_i, exp_v, exp_g, exp_i);
        end
    endtask

    task automatic sampleDut(input int sel, output logic v, output logic [15:0] g, output logic [7:0] i);
        case (sel)
            0:       begin v = if_f.valid; g = 16'(if_f.grant); i = 8'(if_f.grant_idx); end
            1:       begin v = if_r.valid; g = 16'(if_r.grant); i = 8'(if_r.grant_idx); end
            default: begin v = if_w.valid; g = 16'(if_w.grant); i = 8'(if_w.grant_idx); end
        endcase
    endtask

    task automatic checkDirect(input int sel, input string nm,
                               input logic ev, input logic [15:0] eg, input logic [7:0] ei);
        logic v;
        logic [15:0] g;
        logic [7:0] i;
        sampleDut(sel, v, g, i);
        checkOutput(nm, v, g, i, ev, eg, ei);
    endtask

    // Drive one cycle of inputs on the falling edge and queue the state expected after the next rising edge.
    task automatic applyStimulus(input int sel, input logic [15:0] r, input logic a,
                                 input logic ev, input logic [15:0] eg, input logic [7:0] ei,
                                 input string nm);
        exp_t e;
        @(negedge clk);
        if_f.req = '0; if_f.ack = 1'b0;
        if_r.req = '0; if_r.ack = 1'b0;
        if_w.req = '0; if_w.ack = 1'b0;
        case (sel)
            0:       begin if_f.req = r[3:0]; if_f.ack = a; end
            1:       begin if_r.req = r[3:0]; if_r.ack = a; end
            default: begin if_w.req = r;      if_w.ack = a; end
        endcase
        e.sel = sel; e.v = ev; e.g = eg; e.i = ei; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        logic v;
        logic [15:0] g;
        logic [7:0] i;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                sampleDut(e.sel, v, g, i);
                checkOutput(e.name, v, g, i, e.v, e.g, e.i);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [31:0] idx_bits;
        if_f.req = '0; if_f.ack = 1'b0;
        if_r.req = '0; if_r.ack = 1'b0;
        if_w.req = '0; if_w.ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkDirect(0, "reset_fixed", 1'b0, 16'h0000, 8'd0);
        checkDirect(1, "reset_rr",    1'b0, 16'h0000, 8'd0);
        checkDirect(2, "reset_wide",  1'b0, 16'h0000, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fixed mode: hold against changing req, then re-arbitrate on ack
        applyStimulus(0, 16'b0011, 1'b0, 1'b1, 16'b0010, 8'd1, "fix_first");
        for (int k = 0; k < 3; k++)
            applyStimulus(0, 16'b1100, 1'b0, 1'b1, 16'b0010, 8'd1, "fix_hold");
        applyStimulus(0, 16'b1100, 1'b1, 1'b1, 16'b1000, 8'd3, "fix_rearb");
        applyStimulus(0, 16'b0000, 1'b1, 1'b0, 16'b0000, 8'd0, "fix_release");

        // Round-robin rotation with ack held high
        applyStimulus(1, 16'b1111, 1'b1, 1'b1, 16'b1000, 8'd3, "rr_rot0");
        applyStimulus(1, 16'b1111, 1'b1, 1'b1, 16'b0100, 8'd2, "rr_rot1");
        applyStimulus(1, 16'b1111, 1'b1, 1'b1, 16'b0010, 8'd1, "rr_rot2");
        applyStimulus(1, 16'b1111, 1'b1, 1'b1, 16'b0001, 8'd0, "rr_rot3");
        applyStimulus(1, 16'b1111, 1'b1, 1'b1, 16'b1000, 8'd3, "rr_rot4");
        applyStimulus(1, 16'b1111, 1'b1, 1'b1, 16'b0100, 8'd2, "rr_rot5");
        applyStimulus(1, 16'b0000, 1'b1, 1'b0, 16'b0000, 8'd0, "rr_rot_idle");

        // Round-robin wrap: mask 0001 with req 1010 must go to index 3, then back to 1
        applyStimulus(1, 16'b0010, 1'b0, 1'b1, 16'b0010, 8'd1, "rr_wrap_g1");
        applyStimulus(1, 16'b1010, 1'b1, 1'b1, 16'b1000, 8'd3, "rr_wrap_g3");
        applyStimulus(1, 16'b1010, 1'b1, 1'b1, 16'b0010, 8'd1, "rr_wrap_back");
        applyStimulus(1, 16'b0000, 1'b1, 1'b0, 16'b0000, 8'd0, "rr_wrap_idle");

        // Idle with stray ack, then a single request
        for (int k = 0; k < 5; k++)
            applyStimulus(1, 16'b0000, ((k % 2) == 0), 1'b0, 16'b0000, 8'd0, "idle_stray_ack");
        applyStimulus(1, 16'b0100, 1'b0, 1'b1, 16'b0100, 8'd2, "idle_then_req");
        applyStimulus(1, 16'b0100, 1'b0, 1'b1, 16'b0100, 8'd2, "hold_idx2");

        // Asynchronous reset mid-grant, checked without any clock edge
        @(negedge clk);
        if_r.req = '0;
        #2;
        rst = 1'b1;
        #1;
        checkDirect(1, "async_reset_clear", 1'b0, 16'h0000, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 16'b1001, 1'b0, 1'b1, 16'b1000, 8'd3, "reset_mask_restored");
        applyStimulus(1, 16'b0000, 1'b1, 1'b0, 16'b0000, 8'd0, "reset_idle");

        // Width scaling: N=16 fixed
        applyStimulus(2, 16'h0081, 1'b0, 1'b1, 16'h0080, 8'd7,  "wide_first");
        applyStimulus(2, 16'h8000, 1'b0, 1'b1, 16'h0080, 8'd7,  "wide_hold");
        applyStimulus(2, 16'h8000, 1'b1, 1'b1, 16'h8000, 8'd15, "wide_rearb");
        idx_bits = $bits(if_w.grant_idx);
        checks++;
        if (idx_bits != 32'd4) begin
            failures++;
            $display("[TB] FAIL idx_width: got %0d, expected 4", idx_bits);
        end

        // Let the monitor drain the scoreboard within a small cycle budget
        for (int k = 0; k < 4 && sb.size() > 0; k++)
            @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
# priority_arbiter

Parametrised, registered N-input priority arbiter with selectable fixed (MSB-wins) or round-robin priority. It samples a request vector, issues one grant as both a one-hot vector and a binary index, and holds that grant until the consumer acknowledges it. It is the sequential, width-generic successor to the 4-to-2 combinational priority encoder and sits between multiple requesters and a single shared resource.

## Interface
- `N`, default 8: number of request lines; legal range 2..256.
- `ROUND_ROBIN`, default 1:
  - 0 = fixed priority, highest index always wins.
  - 1 = rotating priority.
- `IDX_W`, default `$clog2(N)`: width of the index output. Derived; never overridden.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  N  request lines; bit i set = requester i wants the resource.
- `ack`  input  1  consumer accepts the current grant; meaningful only while `valid`=1.
- `grant`  output  N  registered one-hot grant; all zero when `valid`=0.
- `grant_idx`  output  IDX_W  registered binary index of the granted line; 0 when `valid`=0.
- `valid`  output  1  a grant is being held.

## Operation
- **Two states.**
  - IDLE (`valid`=0).
  - HOLD (`valid`=1).
- **Load condition.** `load = !valid || ack`. On a clock edge where `load` is true, the registers take the arbitration result computed from the `req` present at that edge.
  - `req` nonzero: `valid`←1, `grant`←onehot(w), `grant_idx`←w.
  - `req` zero: `valid`←0, `grant`←0, `grant_idx`←0.
- **HOLD behaviour.** While `ack`=0 in HOLD, the grant is locked. Changes on `req`, including the granted bit dropping, are ignored.
- **`ack` in IDLE.** Ignored.
- **Fixed mode.** w = highest set bit of `req`.
- **Round-robin mode.** Uses a register `mask[N-1:0]`, which resets to all ones.
  - If `req & mask` is nonzero, w = highest set bit of `req & mask`.
  - Otherwise w = highest set bit of `req`.
  - Each time a grant to index k is loaded, `mask` ← bits [k-1:0] set and all others clear. For k=0, `mask` ← 0, so the next search wraps to the top.
  - Effect: priority descends from the last winner and wraps from 0 to N-1.
  - `mask` is updated only when a grant is loaded. It is unchanged on load cycles with `req`=0.
- **Fixed mode and `mask`.** `mask` is held at all ones; synthesis may remove it.
- **Reset.** Asserting `rst` at any time, including mid-HOLD, immediately clears:
  - `valid`=0, `grant`=0, `grant_idx`=0.
  - `mask` returns to all ones.
  - No grant is preserved across reset.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled at edge t gives `valid` high after edge t.
- Back-to-back grants: with `ack`=1 held and `req` nonzero, a new grant loads on every edge, giving one grant per cycle.
- Re-arbitration on `ack` uses `req` at the same edge. In fixed mode, a requester must drop its bit in the `ack` cycle, or it wins again.
- Outputs are driven purely from registers. There is no combinational path from `req` or `ack` to any output.

## Structure
- Shared package `prio_pkg`:
  - `idx_w(n)` function returning clog2 with a minimum of 1.
  - Constants `MODE_FIXED`=0 and `MODE_RR`=1.
- Sub-module `priority_encoder_n` (parameter N): purely combinational.
  - Outputs the highest-set-bit index plus an `any` flag.
  - Instantiated twice: once on `req & mask`, once on `req`.
- The top level holds the state registers, the mask update, the one-hot decode and the load logic.

## Test plan
All scenarios use N=4 unless stated otherwise.
- **Fixed mode, hold then re-arbitrate.** `ROUND_ROBIN`=0, `req`=0011, `ack`=0.
  - Next edge: `valid`=1, `grant`=0010, `grant_idx`=1.
  - Change `req` to 1100 with `ack`=0: grant stays 0010 for 3 cycles.
  - Pulse `ack`=1: next grant is 1000, index 3.
- **Round-robin rotation.** `ROUND_ROBIN`=1, `req`=1111, `ack`=1 constant → successive `grant_idx` is 3, 2, 1, 0, 3, 2.
- **Round-robin wrap.** `ROUND_ROBIN`=1:
  - Grant index 1 (`req`=0010), then `ack` with `req`=1010 → mask=0001, the masked search is empty, so the grant goes to index 3.
  - Then `ack` with `req`=1010 → grant index 1.
- **Idle and stray `ack`.** `req`=0000 with `ack` toggling for 5 cycles → `valid`=0, `grant`=0000, `grant_idx`=0 throughout. A later `req`=0100 → `grant_idx`=2 after 1 cycle.
- **Reset mid-grant.** While `valid`=1 with `grant_idx`=2, assert `rst` between clock edges.
  - Outputs clear immediately, with no clock needed.
  - After release, `req`=1001 → `grant_idx`=3, showing `mask` was restored to all ones.
- **Width scaling.** N=16, `ROUND_ROBIN`=0, `req`=16'h0081 → `grant_idx`=7 and `grant`=16'h0080. Check `IDX_W`=4.
